hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single pipeline clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have ports ifid_rs1 and ifid_rs2, input, 5 each, the source registers of the instruction in ID.
REQ-004 SHALL have port ifid_uses_rs2, input, 1, high when the ID instruction reads rs2.
REQ-005 SHALL have ports idex_rd (input, 5) and idex_memread (input, 1), the destination and load flag of the instruction in EX.
REQ-006 SHALL have port branch_taken_mem, input, 1, high when the branch in MEM resolves taken.
REQ-007 SHALL have ports mc_start (input, 1) and mc_cycles (input, 4): EX holds a multicycle op, and its total EX latency.
REQ-008 SHALL have outputs pc_write, ifid_write and idex_write, 1 each, the pipeline-register enables.
REQ-009 SHALL have outputs ifid_flush, idex_flush and exmem_flush, 1 each, which insert bubbles.
REQ-010 SHALL have output mc_busy, 1, high on every multicycle stall cycle.
REQ-011 SHALL have outputs stall_cycles and flush_events, 16 each, the performance counters.

Function
REQ-012 SHALL implement a two-state FSM with states RUN and MC_WAIT, a 4-bit counter cnt, and a 1-bit flag mc_release.
REQ-013 SHALL default to: all enables 1, all flushes 0, mc_busy 0.
REQ-014 SHALL give priority, highest first: branch flush, then multicycle stall, then load-use stall.
REQ-015 SHALL, in either state when branch_taken_mem=1, assert ifid_flush, idex_flush and exmem_flush, keep enables 1, clear cnt and mc_release, and go to RUN; an MC_WAIT sequence is aborted.
REQ-016 SHALL start a multicycle op in RUN when mc_start=1, mc_cycles>=2 and mc_release=0.
- That cycle: stall (pc_write, ifid_write, idex_write all 0; exmem_flush=1; mc_busy=1).
- Load cnt with mc_cycles-2.
- Next state is MC_WAIT if mc_cycles>2, else RUN with mc_release=1.
REQ-017 SHALL treat mc_cycles of 0 or 1 as a single-cycle op with no stall.
REQ-018 SHALL, in MC_WAIT, apply the same stall outputs and decrement cnt each cycle; when cnt==1, go to RUN and set mc_release=1.
- Total stall cycles equal mc_cycles-1.
REQ-019 SHALL ignore mc_start in the single cycle where mc_release=1 (the release cycle), then clear mc_release.
REQ-020 SHALL detect load-use in RUN when no higher-priority event is active: idex_memread=1, idex_rd!=0, and idex_rd==ifid_rs1 or (ifid_uses_rs2=1 and idex_rd==ifid_rs2).
- Response that cycle: pc_write=0, ifid_write=0, idex_flush=1.
REQ-021 SHALL never report a load-use hazard on x0 (idex_rd==0).
REQ-022 SHALL produce all enable and flush outputs combinationally from state and inputs, with zero latency.

Reset
REQ-023 SHALL, while rst=1, set state RUN, cnt 0, mc_release 0 and both counters 0, and force the default outputs of REQ-013.
REQ-024 SHALL, on reset during MC_WAIT, abandon the sequence immediately; after release, the first edge behaves as RUN.

Configuration
REQ-025 SHALL provide macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments on every cycle with pc_write=0; flush_events increments on every branch-flush cycle; both saturate at 16'hFFFF.
- Undefined: both outputs are constant 0 and no counter registers exist.

Verification
REQ-026 SHALL cover load-use: idex_memread=1, idex_rd=5, ifid_rs1=5 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; the same stimulus with idex_rd=0 gives no stall.
REQ-027 SHALL cover multicycle: mc_start=1, mc_cycles=4 -> exactly 3 consecutive stall cycles with mc_busy=1; the release cycle ignores mc_start; with PERF, stall_cycles=3.
REQ-028 SHALL cover abort: branch_taken_mem=1 on the 2nd stall cycle of mc_cycles=6 -> all three flushes high that cycle; RUN next; no further stalls; with PERF, flush_events=1.
REQ-029 SHALL cover priority: branch_taken_mem, mc_start(mc_cycles=3) and load-use all asserted together -> flush only, no stall, and MC_WAIT is not entered.
REQ-030 SHALL cover reset mid-stall: rst pulsed in MC_WAIT -> outputs return to defaults asynchronously and cnt=0; with PERF, counters read 0.
REQ-031 SHALL cover saturation (PERF): hold a load-use hazard for 70000 cycles -> stall_cycles stays at 16'hFFFF.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: branch flush, multicycle EX stall and load-use stall.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_uses_rs2,
  input  logic [4:0]  idex_rd,
  input  logic        idex_memread,
  input  logic        branch_taken_mem,
  input  logic        mc_start,
  input  logic [3:0]  mc_cycles,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mc_busy,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_mc_release, w_release_nxt;
  logic       w_load_use;
  logic       w_mc_start;

  assign w_load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // The cycle after a multicycle op completes, EX still shows mc_start; that one is ignored.
  assign w_mc_start = (r_state == RUN) && !r_mc_release && mc_start && (mc_cycles >= 4'd2);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_cnt        <= 4'd0;
      r_mc_release <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mc_release <= w_release_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    mc_busy       = 1'b0;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_release_nxt = r_mc_release;

    if (rst) begin
      w_state_nxt   = RUN;
      w_cnt_nxt     = 4'd0;
      w_release_nxt = 1'b0;
    end else if (branch_taken_mem) begin
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      w_state_nxt   = RUN;
      w_cnt_nxt     = 4'd0;
      w_release_nxt = 1'b0;
    end else if ((r_state == MC_WAIT) || w_mc_start) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
      mc_busy     = 1'b1;
      if (r_state == MC_WAIT) begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt   = RUN;
          w_release_nxt = 1'b1;
        end
      end else begin
        w_cnt_nxt = mc_cycles - 4'd2;
        if (mc_cycles > 4'd2) begin
          w_state_nxt = MC_WAIT;
        end else begin
          w_release_nxt = 1'b1;
        end
      end
    end else begin
      w_release_nxt = 1'b0;
      if (w_load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 16'd0;
      r_flush_events <= 16'd0;
    end else begin
      if (!pc_write && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (ifid_flush && (r_flush_events != 16'hFFFF)) r_flush_events <= r_flush_events + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = 16'd0;
  assign flush_events = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: timeline-based reference model, per-cycle compare,
// directed literal checks and randomized stimulus.
module tb_hazard_control_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_busy}
  localparam logic [6:0] O_DEF   = 7'b1110000;
  localparam logic [6:0] O_FLUSH = 7'b1111110;
  localparam logic [6:0] O_STALL = 7'b0000011;
  localparam logic [6:0] O_LU    = 7'b0010100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic        ifid_uses_rs2 = 1'b0, idex_memread = 1'b0, branch_taken_mem = 1'b0, mc_start = 1'b0;
  logic [3:0]  mc_cycles = '0;
  logic        pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_busy;
  logic [15:0] stall_cycles, flush_events;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_control_unit dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .branch_taken_mem(branch_taken_mem),
    .mc_start(mc_start), .mc_cycles(mc_cycles),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mc_busy(mc_busy), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Model: an MC op started at cycle c with latency N stalls cycles c..c+N-2,
  // and cycle c+N-1 is its release cycle.
  typedef struct {
    logic [6:0] o;
    int         stall_end;
    int         rel_at;
  } model_t;

  int m_cyc = 0;
  int m_stall_end = -1;
  int m_rel_at = -1;
  int m_stalls = 0;
  int m_flushes = 0;

  function automatic model_t model_eval();
    model_t m;
    logic   lu;
    m.o         = O_DEF;
    m.stall_end = m_stall_end;
    m.rel_at    = m_rel_at;
    lu = idex_memread && (idex_rd != 0) &&
         ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    if (rst) begin
      m.o = O_DEF;
    end else if (branch_taken_mem) begin
      m.o = O_FLUSH;
      m.stall_end = -1;
      m.rel_at    = -1;
    end else if (m_cyc <= m_stall_end) begin
      m.o = O_STALL;
    end else if ((m_cyc != m_rel_at) && mc_start && (mc_cycles >= 2)) begin
      m.o = O_STALL;
      m.stall_end = m_cyc + int'(mc_cycles) - 2;
      m.rel_at    = m_cyc + int'(mc_cycles) - 1;
    end else if (lu) begin
      m.o = O_LU;
    end
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    model_t mr;
    if (rst) begin
      m_cyc       <= 0;
      m_stall_end <= -1;
      m_rel_at    <= -1;
      m_stalls    <= 0;
      m_flushes   <= 0;
    end else begin
      mr = model_eval();
      if (!mr.o[6] && (m_stalls < 65535)) m_stalls <= m_stalls + 1;
      if (mr.o[3] && (m_flushes < 65535)) m_flushes <= m_flushes + 1;
      m_stall_end <= mr.stall_end;
      m_rel_at    <= mr.rel_at;
      m_cyc       <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin : compare
    model_t mr;
    mr = model_eval();
    check("ctrl_vs_model",
          {25'd0, pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mc_busy},
          {25'd0, mr.o});
    check("stall_cycles_vs_model", {16'd0, stall_cycles}, PERF ? m_stalls : 0);
    check("flush_events_vs_model", {16'd0, flush_events}, PERF ? m_flushes : 0);
  end

  task automatic drive(input logic br, input logic ms, input logic [3:0] mc, input logic mr,
                       input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u2);
    @(posedge clk);
    #1;
    branch_taken_mem = br;
    mc_start         = ms;
    mc_cycles        = mc;
    idex_memread     = mr;
    idex_rd          = rd;
    ifid_rs1         = r1;
    ifid_rs2         = r2;
    ifid_uses_rs2    = u2;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    {branch_taken_mem, mc_start, idex_memread, ifid_uses_rs2} = '0;
    {mc_cycles, idex_rd, ifid_rs1, ifid_rs2} = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #3;
    check("reset_pc_write", {31'd0, pc_write}, 1);
    check("reset_exmem_flush", {31'd0, exmem_flush}, 0);
    check("reset_stall_cycles", {16'd0, stall_cycles}, 0);
    do_reset();

    // Load-use on x5, then the same on x0
    drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    check("lu_pc_write", {31'd0, pc_write}, 0);
    check("lu_ifid_write", {31'd0, ifid_write}, 0);
    check("lu_idex_flush", {31'd0, idex_flush}, 1);
    check("lu_idex_write", {31'd0, idex_write}, 1);
    drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    check("lu_x0_pc_write", {31'd0, pc_write}, 1);
    check("lu_x0_idex_flush", {31'd0, idex_flush}, 0);
    drive(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);
    check("lu_rs2_ifid_write", {31'd0, ifid_write}, 0);
    drive(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0);
    check("lu_rs2_unused_pc_write", {31'd0, pc_write}, 1);

    // Multicycle op, latency 4: three stalls then a release cycle that ignores mc_start
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4'd4, 0, 0, 0, 0, 0);
      check("mc4_busy", {31'd0, mc_busy}, 1);
      check("mc4_pc_write", {31'd0, pc_write}, 0);
    end
    drive(0, 1, 4'd4, 0, 0, 0, 0, 0);
    check("mc4_release_busy", {31'd0, mc_busy}, 0);
    check("mc4_release_idex_write", {31'd0, idex_write}, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("mc4_stall_cycles", {16'd0, stall_cycles}, PERF ? 3 : 0);

    // Branch aborts a latency-6 op on its second stall cycle
    do_reset();
    drive(0, 1, 4'd6, 0, 0, 0, 0, 0);
    check("abort_first_busy", {31'd0, mc_busy}, 1);
    drive(1, 1, 4'd6, 0, 0, 0, 0, 0);
    check("abort_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 3'b111);
    check("abort_busy", {31'd0, mc_busy}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("abort_after_busy", {31'd0, mc_busy}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("abort_flush_events", {16'd0, flush_events}, PERF ? 1 : 0);

    // Branch + multicycle start + load-use together
    do_reset();
    drive(1, 1, 4'd3, 1, 5'd9, 5'd9, 5'd0, 0);
    check("prio_ctrl", {25'd0, pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
                        exmem_flush, mc_busy}, {25'd0, O_FLUSH});
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("prio_no_mc_wait", {31'd0, mc_busy}, 0);

    // Asynchronous reset inside MC_WAIT
    do_reset();
    drive(0, 1, 4'd8, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_busy_before", {31'd0, mc_busy}, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, mc_busy}, 0);
    check("rst_mid_pc_write", {31'd0, pc_write}, 1);
    check("rst_mid_exmem_flush", {31'd0, exmem_flush}, 0);
    check("rst_mid_stall_cycles", {16'd0, stall_cycles}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_after_busy", {31'd0, mc_busy}, 0);
    drive(0, 1, 4'd2, 0, 0, 0, 0, 0);
    check("rst_after_mc2_busy", {31'd0, mc_busy}, 1);
    drive(0, 1, 4'd2, 0, 0, 0, 0, 0);
    check("rst_after_mc2_release", {31'd0, mc_busy}, 0);

    // Randomized traffic with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
            1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Held load-use hazard saturates the stall counter
    do_reset();
    drive(0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
    repeat (70000) @(posedge clk);
    #3;
    check("sat_stall_cycles", {16'd0, stall_cycles}, 32'h0000FFFF);
`endif

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
